// File: rtl/load_store_unit.sv
// RV64 load/store unit: a single-outstanding FSM that turns one pipeline request into
// at most one read and one write of an aligned 64-bit data memory word.
module load_store_unit #(
    parameter int IDX_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    // Memory is word-addressed; the word index occupies bits [IDX_BITS+2:3].
    assign mem_address = {addr_q[63:IDX_BITS+3], addr_q[IDX_BITS+2:3], 3'b000};

    function automatic logic is_fault(input logic wr, input logic [2:0] f3,
                                      input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        if (f3 == 3'b111 || (wr && f3[2]))
            bad = 1'b1;
        else begin
            case (f3[1:0])
                2'b01:   bad = off[0];
                2'b10:   bad = |off[1:0];
                2'b11:   bad = |off;
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [2:0] off,
                                                input logic [63:0] word);
        logic [63:0] lane;
        logic [63:0] result;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  result = {{56{lane[7]}}, lane[7:0]};
            3'b001:  result = {{48{lane[15]}}, lane[15:0]};
            3'b010:  result = {{32{lane[31]}}, lane[31:0]};
            3'b011:  result = lane;
            3'b100:  result = {56'd0, lane[7:0]};
            3'b101:  result = {48'd0, lane[15:0]};
            3'b110:  result = {32'd0, lane[31:0]};
            default: result = 64'd0;
        endcase
        return result;
    endfunction

    // Replace only the addressed bytes of the old word with the low bytes of the store data.
    function automatic logic [63:0] merge_store(input logic [1:0] size, input logic [2:0] off,
                                                input logic [63:0] old_word,
                                                input logic [63:0] wd);
        logic [63:0] mask;
        case (size)
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (old_word & ~mask) | ((wd << {off, 3'b000}) & mask);
    endfunction

    // Strobes and response are one-cycle pulses by default; each state re-raises what it owns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            write_q        <= 1'b0;
            funct3_q       <= 3'd0;
            addr_q         <= 64'd0;
            wdata_q        <= 64'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 64'd0;
            resp_fault     <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= 64'd0;
        end else begin
            resp_valid     <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= 64'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_fault(req_write, req_funct3, req_addr[2:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 64'd0;
                        end else if (req_write && req_funct3[1:0] == 2'b11) begin
                            state          <= WRITE;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state    <= READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        state          <= WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= merge_store(funct3_q[1:0], addr_q[2:0],
                                                      mem_read_data, wdata_q);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= load_extend(funct3_q, addr_q[2:0], mem_read_data);
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= 64'd0;
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_rdata <= 64'd0;
                    resp_fault <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter `IDX_BITS`, default 10, giving the memory word-index width: 1024 words, using address bits [IDX_BITS+2:3].
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `req_valid`, input, 1 bit: the pipeline presents a memory request.
REQ-005 SHALL have port `req_ready`, output, 1 bit: the unit can accept a request this cycle.
REQ-006 SHALL have port `req_write`, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port `req_funct3`, input, 3 bits: RV64 size/sign code.
- Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- Stores: 000 SB, 001 SH, 010 SW, 011 SD.
REQ-008 SHALL have port `req_addr`, input, 64 bits: byte address.
REQ-009 SHALL have port `req_wdata`, input, 64 bits: store data, right-aligned.
REQ-010 SHALL have port `resp_valid`, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port `resp_rdata`, output, 64 bits: extended load result; 0 for stores and faults.
REQ-012 SHALL have port `resp_fault`, output, 1 bit: misaligned address or illegal funct3; valid with `resp_valid`.
REQ-013 SHALL have port `mem_read`, output, 1 bit: read strobe to data memory.
REQ-014 SHALL have port `mem_write`, output, 1 bit: write strobe to data memory; memory commits on the `clk` rising edge.
REQ-015 SHALL have port `mem_address`, output, 64 bits: always {addr[63:3], 3'b000}.
REQ-016 SHALL have port `mem_write_data`, output, 64 bits: the full merged doubleword.
REQ-017 SHALL have port `mem_read_data`, input, 64 bits: combinational read data, valid in the same cycle as `mem_read`.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; `req_ready` = 1 only in IDLE.
REQ-019 SHALL accept a request on `req_valid` && `req_ready` and latch write, funct3, addr and wdata.
REQ-020 SHALL classify a request as a fault when either condition holds:
- funct3 = 111, or store funct3 ≥ 100;
- size misaligned: H requires addr[0] = 0; W requires addr[1:0] = 0; D requires addr[2:0] = 0.
REQ-021 SHALL route requests from IDLE as follows:
- fault → RESP;
- load → READ;
- SD → WRITE;
- SB/SH/SW → READ.
REQ-022 SHALL, in READ, assert `mem_read` for exactly one cycle.
- Loads: capture the lane selected by addr[2:0] (little-endian), sign-extend for 000/001/010 and zero-extend for 011–110, then go to RESP.
- Sub-word stores: capture `mem_read_data` with only the addressed bytes replaced by the low bytes of wdata, then go to WRITE.
REQ-023 SHALL, in WRITE, assert `mem_write` for exactly one cycle with the merged word (SD: wdata unmodified), then go to RESP.
REQ-024 SHALL, in RESP, drive `resp_valid` = 1 for one cycle, then return to IDLE.
REQ-025 SHALL give these accept-to-`resp_valid` latencies: load 2 cycles, SD 2, SB/SH/SW 3, fault 1.
REQ-026 SHALL never assert `mem_read` and `mem_write` in the same cycle.
REQ-027 SHALL never assert either strobe for a faulting request.
REQ-028 SHALL hold `mem_read`, `mem_write` and `mem_write_data` at 0 when not strobing.
REQ-029 SHALL ignore `req_valid` outside IDLE; a request must be held until it is accepted.
REQ-030 SHALL allow a new request to be accepted in the cycle immediately after RESP (back-to-back operation).

Reset
REQ-031 SHALL, while `reset` = 1, immediately force state to IDLE and all outputs to 0, except `req_ready`, which shall be 1.
REQ-032 SHALL abandon any in-flight operation on reset; a reset asserted during WRITE before the clock edge shall produce no memory write.
REQ-033 SHALL clear all latched request and result registers to 0 on reset.

Verification
Preload memory word at 0x08 = 0x8877665544332211 for scenarios 1–3.
REQ-034 SHALL cover: LB at addr 0x0F → after 2 cycles `resp_rdata` = 0xFFFFFFFFFFFFFF88, `resp_fault` = 0; LBU at the same address → 0x0000000000000088.
REQ-035 SHALL cover: SH wdata = 0xBEEF at addr 0x0A → one `mem_read`, then one `mem_write` with data 0x88776655BEEF2211; `resp_valid` 3 cycles after accept.
REQ-036 SHALL cover: LW at addr 0x0A → `resp_valid` = 1 and `resp_fault` = 1 after 1 cycle, `mem_read` never asserted; funct3 = 111 gives the same response.
REQ-037 SHALL cover: SD 0x14 at addr 0x08, then LD at 0x08 back-to-back → LD returns 0x0000000000000014; `req_ready` low throughout both operations except IDLE cycles.
REQ-038 SHALL cover: `reset` asserted mid-cycle in WRITE of an SW → `mem_write` drops immediately, memory is unchanged, `req_ready` = 1, `resp_valid` = 0.
